button_debounce_multi: RTL and testbench
========================================

# button_debounce_multi

Parametrised, multi-channel successor to the single-button debouncer. It takes N raw mechanical inputs and runs each through a 2-FF synchroniser and an independent debounce counter. Each channel produces a clean level plus single-cycle press and release pulses, with optional long-press detection. It sits between board pins (keys/switches) and the control FSMs, which consume the pulses directly and need no edge detection of their own.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels (≥1)
- DEBOUNCE_CYCLES, 500_000: consecutive stable cycles required to accept a change (10 ms at 50 MHz); ≥2
- ACTIVE_LOW, 1: 1 = raw input low means pressed; 0 = high means pressed
- LONG_CYCLES, 50_000_000: cycles of held press before the long-press pulse (1 s at 50 MHz); used only with the long-press macro; must be > DEBOUNCE_CYCLES

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- btn_in  in  NUM_CH  raw asynchronous button pins
- btn_level  out  NUM_CH  debounced level, 1 = pressed
- btn_press  out  NUM_CH  1-cycle pulse on the debounced released→pressed transition
- btn_release  out  NUM_CH  1-cycle pulse on the debounced pressed→released transition
- btn_long  out  NUM_CH  1-cycle long-press pulse; tied 0 when the macro is absent

## Operation
- Polarity: each raw bit is inverted first when ACTIVE_LOW=1, so internal logic is always "1 = pressed".
- Synchroniser: 2 flops per channel. Reset value is 0 (released).
- Per-channel counter, width $clog2(DEBOUNCE_CYCLES):
  - If synced == stable: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES−1: stable ← synced, counter ← 0.
  - Else: counter ← counter+1.
- Any return to the old level before terminal count discards progress. A glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches the output.
- btn_press / btn_release are registered and assert in the same cycle that btn_level takes its new value. They are never asserted simultaneously on one channel.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Long press (macro on):
  - A hold counter, width $clog2(LONG_CYCLES+1), clears whenever btn_level=0.
  - It increments while btn_level=1 and saturates at LONG_CYCLES.
  - btn_long pulses once, in the cycle the counter reaches LONG_CYCLES.
  - There is no repeat. A release followed by a re-press rearms it.

## Timing
- Reset (asynchronous assert; release is synchronous to clk, handled upstream): all synchroniser flops, counters, btn_level, btn_press, btn_release and btn_long are 0.
- Latency: a clean edge on btn_in first sampled at edge k appears on btn_level and the pulse outputs after edge k+2+DEBOUNCE_CYCLES.
- Long pulse: asserts LONG_CYCLES cycles after the btn_press cycle.
- Pulse width: exactly 1 cycle for all pulse outputs.
- Reset mid-count: progress is lost and the channel restarts from released. A button held through reset produces btn_press after the normal latency once reset deasserts.
- Release exactly at the long-press terminal cycle: btn_long still pulses if the hold counter reached LONG_CYCLES on that edge. The release pulse follows after debounce latency.

## Configuration
- BUTTON_LONG_PRESS_EN:
  - Defined: hold counters and btn_long logic are instantiated per channel.
  - Undefined: no hold counters exist, btn_long is driven constant 0, and LONG_CYCLES is ignored.

## Structure
- Package button_pkg holds:
  - default constants DEBOUNCE_10MS_50MHZ = 500_000 and LONG_1S_50MHZ = 50_000_000
  - a function computing counter width ($clog2 wrapper, minimum 1)
- Sub-module debounce_channel contains one channel's synchroniser, debounce counter, edge pulses and optional hold counter. The top generates NUM_CH instances and applies the polarity inversion.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=0, NUM_CH=4.
- Clean press: btn_in[0] rises and holds → btn_level[0]=1 and btn_press[0]=1 for one cycle, 6 edges after first sample; no other channel toggles.
- Glitch: btn_in[1] high for 3 cycles then low → btn_level[1], btn_press[1] and btn_release[1] stay 0 throughout.
- Bounce: btn_in[2] toggles 1,0,1,1,0 then holds 1 → single btn_press[2] exactly 6 edges after the final rise; no release pulse.
- Simultaneous: channels 0 and 3 press on the same edge → both btn_press bits pulse in the same cycle. Release → both btn_release bits pulse together.
- Long press (macro on): hold channel 0 → btn_long[0] pulses once, 20 cycles after btn_press[0], and not again while held. Macro off → btn_long stays 0.
- Reset mid-count: assert rst_n low 2 cycles into a debounce → all outputs 0 immediately. After release with the button still held → btn_press 6 edges later.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and sizing helper for the multi-channel button debouncer.
// Optional feature macro used by this slice: BUTTON_LONG_PRESS_EN.
package button_pkg;

   localparam int unsigned DEBOUNCE_10MS_50MHZ = 500_000;
   localparam int unsigned LONG_1S_50MHZ       = 50_000_000;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      if (n > 1) w = $clog2(n);
      return w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: 2-FF synchroniser, stability counter,
// registered level/press/release, and a hold counter for long presses when
// BUTTON_LONG_PRESS_EN is defined (otherwise o_long is tied low).
module debounce_channel
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
   parameter int unsigned LONG_CYCLES     = LONG_1S_50MHZ
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long
);

   localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   // A long-press threshold at or below the debounce window is meaningless.
   if ((LONG_CYCLES <= DEBOUNCE_CYCLES) || (DEBOUNCE_CYCLES < 2)) begin : g_invalid_cfg
   end

   // Two-flop synchroniser for the asynchronous pin (already polarity-corrected).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else if (r_sync2 == r_stable) begin
         r_cnt    <= '0;
      end else if (r_cnt == CNT_TERM) begin
         r_stable <= r_sync2;
         r_cnt    <= '0;
      end else begin
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   // Registered level with press/release pulses aligned to the level change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_level   <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
      end else begin
         o_level   <= r_stable;
         o_press   <= r_stable & ~o_level;
         o_release <= ~r_stable & o_level;
      end
   end

`ifdef BUTTON_LONG_PRESS_EN
   localparam int unsigned        HOLD_W   = cnt_width(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0]  HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

   logic [HOLD_W-1:0] r_hold;

   // Saturating count of cycles the debounced level has been pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold <= '0;
      end else if (!o_level) begin
         r_hold <= '0;
      end else if (r_hold != HOLD_MAX) begin
         r_hold <= r_hold + HOLD_W'(1);
      end
   end

   // Single pulse on the edge where the hold count reaches its terminal value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_long <= 1'b0;
      end else begin
         o_long <= o_level & (r_hold == HOLD_PRE);
      end
   end
`else
   assign o_long = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_multi.sv
// N-channel button debouncer: polarity normalisation plus one debounce_channel
// per pin. Long-press pulses exist only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce_multi
   import button_pkg::*;
#(
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
   parameter int unsigned ACTIVE_LOW      = 1,
   parameter int unsigned LONG_CYCLES     = LONG_1S_50MHZ
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] btn_in,
   output logic [NUM_CH-1:0] btn_level,
   output logic [NUM_CH-1:0] btn_press,
   output logic [NUM_CH-1:0] btn_release,
   output logic [NUM_CH-1:0] btn_long
);

   logic [NUM_CH-1:0] w_raw;

   // Internal convention is always 1 = pressed.
   assign w_raw = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

   // Independent channel per pin.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_raw     (w_raw[g]),
         .o_level   (btn_level[g]),
         .o_press   (btn_press[g]),
         .o_release (btn_release[g]),
         .o_long    (btn_long[g])
      );
   end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi (NUM_CH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// ACTIVE_LOW=0). Long-press expectations follow BUTTON_LONG_PRESS_EN.
module tb_button_debounce_multi;

   localparam int N = 4;
   localparam int D = 4;
   localparam int L = 20;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] btn_in;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_press;
   logic [N-1:0] btn_release;
   logic [N-1:0] btn_long;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   button_debounce_multi #(
      .NUM_CH          (N),
      .DEBOUNCE_CYCLES (D),
      .ACTIVE_LOW      (0),
      .LONG_CYCLES     (L)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long)
   );

   // Reference model: a channel flips when the D samples that have cleared the
   // synchroniser all disagree with the accepted level; outputs lag one edge.
   logic [N-1:0] m_lvl    = '0;
   logic [N-1:0] m_prs    = '0;
   logic [N-1:0] m_rel    = '0;
   logic [N-1:0] m_long   = '0;
   logic [N-1:0] m_stable = '0;
   logic [N-1:0] hist [D+2];
   int           run  [N];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lvl = '0; m_prs = '0; m_rel = '0; m_long = '0; m_stable = '0;
         for (int i = 0; i < D + 2; i++) hist[i] = '0;
         for (int c = 0; c < N; c++) run[c] = 0;
      end else begin
         for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = btn_in;
         for (int c = 0; c < N; c++) begin
            logic old_lvl;
            logic uniform;
            old_lvl  = m_lvl[c];
            m_prs[c] = m_stable[c] & ~old_lvl;
            m_rel[c] = ~m_stable[c] & old_lvl;
`ifdef BUTTON_LONG_PRESS_EN
            m_long[c] = old_lvl && (run[c] == L);
`else
            m_long[c] = 1'b0;
`endif
            m_lvl[c] = m_stable[c];
            run[c]   = m_lvl[c] ? run[c] + 1 : 0;
            uniform  = 1'b1;
            for (int i = 2; i <= D + 1; i++)
               if (hist[i][c] == m_stable[c]) uniform = 1'b0;
            if (uniform) m_stable[c] = ~m_stable[c];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Advance to the next falling edge and compare everything against the model.
   task automatic step();
      @(negedge clk);
      check($sformatf("model@%0t", $time),
            32'({btn_level, btn_press, btn_release, btn_long}),
            32'({m_lvl, m_prs, m_rel, m_long}));
   endtask

   typedef struct {
      logic [N-1:0] in;
      logic [N-1:0] lvl;
      logic [N-1:0] prs;
      logic [N-1:0] rel;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [N-1:0] i, input logic [N-1:0] l,
                               input logic [N-1:0] p, input logic [N-1:0] r, input int n);
      vec_t v;
      v.in = i; v.lvl = l; v.prs = p; v.rel = r;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endfunction

   // Loops index n=1 as the first edge that samples a new input; the
   // debounced change is therefore expected at n = 1 + 2 + D = 7.

   task automatic bounce_test();
      int pat [5] = '{1, 0, 1, 1, 0};
      int np = 0, nr = 0, at = -1;
      foreach (pat[i]) begin
         btn_in[2] = 1'(pat[i]);
         step();
         np += int'(btn_press[2]);
         nr += int'(btn_release[2]);
      end
      btn_in[2] = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         step();
         if (btn_press[2]) begin np++; at = n; end
         nr += int'(btn_release[2]);
      end
      check("bounce_press_count", 32'(np), 32'd1);
      check("bounce_press_edge",  32'(at), 32'd7);
      check("bounce_no_release",  32'(nr), 32'd0);
      btn_in[2] = 1'b0;
      repeat (10) step();
   endtask

   task automatic simul_test();
      int a0 = -1, a3 = -1;
      btn_in = 4'b1001;
      for (int n = 1; n <= 10; n++) begin
         step();
         if (btn_press[0] && a0 < 0) a0 = n;
         if (btn_press[3] && a3 < 0) a3 = n;
      end
      check("simul_press_ch0", 32'(a0), 32'd7);
      check("simul_press_ch3", 32'(a3), 32'd7);
      a0 = -1; a3 = -1;
      btn_in = 4'b0000;
      for (int n = 1; n <= 10; n++) begin
         step();
         if (btn_release[0] && a0 < 0) a0 = n;
         if (btn_release[3] && a3 < 0) a3 = n;
      end
      check("simul_release_ch0", 32'(a0), 32'd7);
      check("simul_release_ch3", 32'(a3), 32'd7);
      repeat (4) step();
   endtask

   task automatic long_test();
      int p = -1, lc = 0, la = -1;
      btn_in = 4'b0001;
      for (int n = 1; n <= 50; n++) begin
         step();
         if (btn_press[0] && p < 0) p = n;
         if (btn_long[0]) begin lc++; la = n; end
      end
      check("long_press_edge", 32'(p), 32'd7);
`ifdef BUTTON_LONG_PRESS_EN
      check("long_pulse_count", 32'(lc), 32'd1);
      check("long_after_press", 32'(la - p), 32'(L));
`else
      check("long_tied_low", 32'(lc), 32'd0);
`endif
      btn_in = 4'b0000;
      repeat (10) step();
   endtask

   task automatic reset_mid_test();
      int a0 = -1, a1 = -1;
      btn_in = 4'b0001;
      repeat (9) step();
      check("rstmid_pre_level", 32'(btn_level), 32'h1);
      btn_in[1] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("rstmid_async_clear",
               32'({btn_level, btn_press, btn_release, btn_long}), 32'h0);
      repeat (3) step();
      rst_n = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         step();
         if (btn_press[0] && a0 < 0) a0 = n;
         if (btn_press[1] && a1 < 0) a1 = n;
      end
      check("rstmid_repress_ch0", 32'(a0), 32'd7);
      check("rstmid_repress_ch1", 32'(a1), 32'd7);
      btn_in = 4'b0000;
      repeat (10) step();
   endtask

   task automatic random_test();
      int rate = 8;
      int rst_hold = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 100 == 0) begin
            case ($urandom_range(2))
               0:       rate = 2;
               1:       rate = 6;
               default: rate = 40;
            endcase
         end
         for (int c = 0; c < N; c++)
            if ($urandom_range(rate - 1) == 0) btn_in[c] = ~btn_in[c];
         if (rst_hold > 0) begin
            rst_n = 1'b0;
            rst_hold--;
         end else begin
            rst_n = 1'b1;
            if ($urandom_range(699) == 0) rst_hold = $urandom_range(3, 1);
         end
         step();
      end
      rst_n = 1'b1;
      btn_in = '0;
      repeat (10) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n  = 1'b0;
      btn_in = '0;
      repeat (3) step();
      check("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_long}), 32'h0);
      rst_n = 1'b1;

      // Clean press on ch0, 3-cycle glitch on ch1, then release of ch0.
      add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 6);
      add(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
      add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
      add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 3);
      add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 7);
      add(4'b0000, 4'b0001, 4'b0000, 4'b0000, 6);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0001, 1);
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
      foreach (tbl[i]) begin
         btn_in = tbl[i].in;
         step();
         check($sformatf("tbl[%0d]", i),
               32'({btn_level, btn_press, btn_release, btn_long}),
               32'({tbl[i].lvl, tbl[i].prs, tbl[i].rel, 4'b0000}));
      end

      bounce_test();
      simul_test();
      long_test();
      reset_mid_test();
      random_test();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
